rtc_bus_arbiter: RTL and testbench

- Owns the multiplexed address/data bus of the external RTC (chip_select, read, write, a_d, 8-bit shared bus).
- Shares that bus between two requesters:
  - port W: write requester, driven by the programming/stopwatch state machines.
  - port R: read requester, driven by the periodic time-refresh engine.
- Sequences each granted request as one complete address-phase plus data-phase transaction with parameterised strobe timing.
- Sits between the state-machine cluster and the top-level tristate pad, which is built from bus_out/bus_oe/bus_in.

---
 rtl/rtc_bus_pkg.sv | 25 ++
 rtl/rtc_phase_timer.sv | 27 ++
 rtl/rtc_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus arbiter: state encoding, default phase
// timings and requester port identifiers.
package rtc_bus_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    A_SETUP   = 3'd1,
    A_STROBE  = 3'd2,
    A_HOLD    = 3'd3,
    D_SETUP   = 3'd4,
    D_STROBE  = 3'd5,
    D_HOLD    = 3'd6,
    GAP       = 3'd7
  } state_t;

  localparam int DEF_T_SETUP = 2;
  localparam int DEF_T_PULSE = 8;
  localparam int DEF_T_HOLD  = 2;
  localparam int DEF_T_GAP   = 4;
  localparam int DEF_CW      = 4;

  localparam logic PORT_W = 1'b0;
  localparam logic PORT_R = 1'b1;

endpackage

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing each bus phase; 'last' marks the final cycle
// of the phase so the FSM can advance on the following edge.
module rtc_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg > CW'(1)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign last = (count_reg == CW'(1));

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter for the external RTC multiplexed bus: runs one address
// phase plus one data phase per grant, with registered pad and strobe outputs.
module rtc_bus_arbiter
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = DEF_T_SETUP,
  parameter int T_PULSE = DEF_T_PULSE,
  parameter int T_HOLD  = DEF_T_HOLD,
  parameter int T_GAP   = DEF_T_GAP,
  parameter int CW      = DEF_CW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_w,
  input  logic [7:0] addr_w,
  input  logic [7:0] wdata_w,
  input  logic       req_r,
  input  logic [7:0] addr_r,
  output logic       ack_w,
  output logic       ack_r,
  output logic [7:0] rdata,
  output logic       busy,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       chip_select,
  output logic       read,
  output logic       write,
  output logic       a_d
);

  state_t     state_reg, state_next;
  logic       dir_reg, dir_next;
  logic       last_grant_reg, last_grant_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] wdata_reg, wdata_next;
  logic [7:0] rdata_reg;
  logic       ack_w_reg, ack_r_reg;
  logic       cs_reg, rd_reg, wr_reg, ad_reg, oe_reg;
  logic       cs_next, rd_next, wr_next, ad_next, oe_next;
  logic [7:0] out_reg, out_next;
  logic          timer_load, phase_last;
  logic [CW-1:0] timer_val;

  function automatic logic [CW-1:0] phase_len(input state_t s);
    case (s)
      A_SETUP, D_SETUP:   return CW'(T_SETUP);
      A_STROBE, D_STROBE: return CW'(T_PULSE);
      A_HOLD, D_HOLD:     return CW'(T_HOLD);
      GAP:                return CW'(T_GAP);
      default:            return '0;
    endcase
  endfunction

  rtc_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .last     (phase_last)
  );

  always_comb begin
    state_next      = state_reg;
    dir_next        = dir_reg;
    last_grant_next = last_grant_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (req_w && (!req_r || last_grant_reg == PORT_R)) begin
          state_next      = A_SETUP;
          dir_next        = PORT_W;
          last_grant_next = PORT_W;
          addr_next       = addr_w;
          wdata_next      = wdata_w;
        end else if (req_r) begin
          state_next      = A_SETUP;
          dir_next        = PORT_R;
          last_grant_next = PORT_R;
          addr_next       = addr_r;
        end
      end
      A_SETUP:  if (phase_last) state_next = A_STROBE;
      A_STROBE: if (phase_last) state_next = A_HOLD;
      A_HOLD:   if (phase_last) state_next = D_SETUP;
      D_SETUP:  if (phase_last) state_next = D_STROBE;
      D_STROBE: if (phase_last) state_next = D_HOLD;
      D_HOLD:   if (phase_last) state_next = GAP;
      GAP:      if (phase_last) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    timer_load = (state_next != state_reg);
    timer_val  = phase_len(state_next);
  end

  // Pad and strobe values are decoded from the next state and registered,
  // so the external chip never sees decode glitches.
  always_comb begin
    cs_next  = 1'b1;
    rd_next  = 1'b1;
    wr_next  = 1'b1;
    ad_next  = 1'b0;
    oe_next  = 1'b0;
    out_next = '0;
    case (state_next)
      A_SETUP, A_HOLD: begin
        oe_next  = 1'b1;
        out_next = addr_next;
      end
      A_STROBE: begin
        oe_next  = 1'b1;
        out_next = addr_next;
        cs_next  = 1'b0;
        wr_next  = 1'b0;
      end
      D_SETUP, D_HOLD: begin
        ad_next = 1'b1;
        if (dir_next == PORT_W) begin
          oe_next  = 1'b1;
          out_next = wdata_next;
        end
      end
      D_STROBE: begin
        ad_next = 1'b1;
        cs_next = 1'b0;
        if (dir_next == PORT_W) begin
          oe_next  = 1'b1;
          out_next = wdata_next;
          wr_next  = 1'b0;
        end else begin
          rd_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      dir_reg        <= PORT_W;
      last_grant_reg <= PORT_R;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rdata_reg      <= '0;
      ack_w_reg      <= 1'b0;
      ack_r_reg      <= 1'b0;
      cs_reg         <= 1'b1;
      rd_reg         <= 1'b1;
      wr_reg         <= 1'b1;
      ad_reg         <= 1'b0;
      oe_reg         <= 1'b0;
      out_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      dir_reg        <= dir_next;
      last_grant_reg <= last_grant_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      ack_w_reg      <= (state_reg == D_HOLD) && phase_last && (dir_reg == PORT_W);
      ack_r_reg      <= (state_reg == D_HOLD) && phase_last && (dir_reg == PORT_R);
      if ((state_reg == D_STROBE) && phase_last && (dir_reg == PORT_R)) begin
        rdata_reg <= bus_in;
      end
      cs_reg  <= cs_next;
      rd_reg  <= rd_next;
      wr_reg  <= wr_next;
      ad_reg  <= ad_next;
      oe_reg  <= oe_next;
      out_reg <= out_next;
    end
  end

  assign busy        = (state_reg != IDLE);
  assign ack_w       = ack_w_reg;
  assign ack_r       = ack_r_reg;
  assign rdata       = rdata_reg;
  assign chip_select = cs_reg;
  assign read        = rd_reg;
  assign write       = wr_reg;
  assign a_d         = ad_reg;
  assign bus_oe      = oe_reg;
  assign bus_out     = out_reg;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Self-checking bench: a bus monitor scoreboards every acked transaction on the
// default-timing instance; a second instance checks the minimum-timing waveform.
module tb_rtc_bus_arbiter;

  localparam int TS = 2, TP = 8, TH = 2, TG = 4;
  localparam int LAT = 1 + 2 * (TS + TP + TH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset;
  logic       req_w, req_r;
  logic [7:0] addr_w, wdata_w, addr_r;
  logic       ack_w, ack_r, busy, bus_oe, chip_select, read, write, a_d;
  logic [7:0] rdata, bus_in, bus_out;
  logic [7:0] rd_val = 8'h00;

  logic       s_req_w, s_req_r;
  logic [7:0] s_addr_w, s_wdata_w, s_addr_r;
  logic       s_ack_w, s_ack_r, s_busy, s_bus_oe, s_chip_select, s_read, s_write, s_a_d;
  logic [7:0] s_rdata, s_bus_in, s_bus_out;
  logic [7:0] s_rd_val = 8'h00;

  // Bench plays the RTC: it drives the read value only while read is low.
  assign bus_in   = read ? 8'hEE : rd_val;
  assign s_bus_in = s_read ? 8'h11 : s_rd_val;

  rtc_bus_arbiter #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_GAP(TG), .CW(4)) dut (
    .clk(clk), .reset(reset), .req_w(req_w), .addr_w(addr_w), .wdata_w(wdata_w),
    .req_r(req_r), .addr_r(addr_r), .ack_w(ack_w), .ack_r(ack_r), .rdata(rdata),
    .busy(busy), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
    .chip_select(chip_select), .read(read), .write(write), .a_d(a_d)
  );

  rtc_bus_arbiter #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1), .T_GAP(1), .CW(4)) dut_fast (
    .clk(clk), .reset(reset), .req_w(s_req_w), .addr_w(s_addr_w), .wdata_w(s_wdata_w),
    .req_r(s_req_r), .addr_r(s_addr_r), .ack_w(s_ack_w), .ack_r(s_ack_r), .rdata(s_rdata),
    .busy(s_busy), .bus_in(s_bus_in), .bus_out(s_bus_out), .bus_oe(s_bus_oe),
    .chip_select(s_chip_select), .read(s_read), .write(s_write), .a_d(s_a_d)
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic       is_w;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input logic is_w, input logic [7:0] addr, input logic [7:0] data);
    exp_t x;
    x.is_w = is_w;
    x.addr = addr;
    x.data = data;
    exp_q.push_back(x);
  endtask

  // ---------------- bus monitor / scoreboard ----------------
  int a_cnt, a_w, d_cnt, d_w, d_r, start_cyc;
  logic a_rd_low, a_oe_bad, d_oe_any;
  logic [7:0] a_addr, d_out;
  logic cs_p, wr_p, rd_p, ad_p, oe_p, busy_p, ack_p;
  exp_t e;

  task automatic clear_mon();
    a_cnt = 0; a_w = 0; d_cnt = 0; d_w = 0; d_r = 0;
    a_rd_low = 1'b0; a_oe_bad = 1'b0; d_oe_any = 1'b0;
    a_addr = 8'h00; d_out = 8'h00;
  endtask

  initial begin
    clear_mon();
    start_cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        clear_mon();
      end else begin
        if (!busy_p && busy) start_cyc = cyc;
        if (chip_select != cs_p || write != wr_p || read != rd_p)
          chk("strobe_edge_vs_ad_oe", 32'({a_d, bus_oe}), 32'({ad_p, oe_p}));
        if (ack_p) chk("ack_one_cycle", 32'({ack_w, ack_r}), 32'd0);
        if (!a_d) begin
          if (!chip_select) begin
            a_cnt++;
            a_addr = bus_out;
            if (!bus_oe) a_oe_bad = 1'b1;
          end
          if (!write) a_w++;
          if (!read) a_rd_low = 1'b1;
        end else begin
          if (bus_oe) d_oe_any = 1'b1;
          if (!chip_select) begin
            d_cnt++;
            d_out = bus_out;
          end
          if (!write) d_w++;
          if (!read) d_r++;
        end
        if (ack_w || ack_r) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'({ack_w, ack_r}), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("granted_port", 32'({ack_w, ack_r}), 32'({e.is_w, !e.is_w}));
            chk("addr_on_bus", 32'(a_addr), 32'(e.addr));
            chk("addr_phase_oe", 32'(a_oe_bad), 32'd0);
            chk("addr_strobe_len", 32'(a_cnt), 32'(TP));
            chk("addr_write_len", 32'(a_w), 32'(TP));
            chk("addr_read_low", 32'(a_rd_low), 32'd0);
            chk("data_strobe_len", 32'(d_cnt), 32'(TP));
            chk("data_write_len", 32'(d_w), e.is_w ? 32'(TP) : 32'd0);
            chk("data_read_len", 32'(d_r), e.is_w ? 32'd0 : 32'(TP));
            chk("data_phase_oe", 32'(d_oe_any), 32'(e.is_w));
            chk("data_value", 32'(e.is_w ? d_out : rdata), 32'(e.data));
            chk("start_to_ack", 32'(cyc - start_cyc), 32'(LAT - 1));
          end
          clear_mon();
        end
      end
      cs_p = chip_select; wr_p = write; rd_p = read; ad_p = a_d; oe_p = bus_oe;
      busy_p = busy; ack_p = ack_w | ack_r;
    end
  end

  // ---------------- stimulus ----------------
  // kind: 0 ack_w, 1 ack_r, 2 busy, 3 idle, 4 data strobe
  task automatic wait_ev(input int kind, input string name, output int at);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      case (kind)
        0: hit = ack_w;
        1: hit = ack_r;
        2: hit = busy;
        3: hit = !busy;
        default: hit = a_d && !chip_select;
      endcase
      if (hit) break;
    end
    at = cyc;
    if (!hit) begin
      n_checks++;
      n_err++;
      $display("FAIL timeout_%s: event not seen within 200 cycles", name);
    end
  endtask

  typedef struct {
    logic       is_w;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd_val;
  } vec_t;
  vec_t vec [6];

  logic [6:0] fast_w [9];
  logic [6:0] fast_r [9];

  initial begin
    int t0, t1, t2, k;
    logic [7:0] last_rd;

    vec[0] = '{1'b1, 8'h21, 8'h45, 8'h00};
    vec[1] = '{1'b0, 8'h22, 8'h00, 8'h37};
    vec[2] = '{1'b1, 8'h00, 8'hFF, 8'h00};
    vec[3] = '{1'b0, 8'hFF, 8'h00, 8'hA5};
    vec[4] = '{1'b1, 8'h5A, 8'hC3, 8'h00};
    vec[5] = '{1'b0, 8'h81, 8'h00, 8'h00};
    // {a_d, bus_oe, chip_select, write, read, ack, busy} for offsets 0..8 from request
    fast_w = '{7'b0011100, 7'b0111101, 7'b0100101, 7'b0111101, 7'b1111101,
               7'b1100101, 7'b1111101, 7'b0011111, 7'b0011100};
    fast_r = '{7'b0011100, 7'b0111101, 7'b0100101, 7'b0111101, 7'b1011101,
               7'b1001001, 7'b1011101, 7'b0011111, 7'b0011100};

    reset = 1'b0;
    req_w = 1'b0; req_r = 1'b0; addr_w = 8'h00; wdata_w = 8'h00; addr_r = 8'h00;
    s_req_w = 1'b0; s_req_r = 1'b0; s_addr_w = 8'h00; s_wdata_w = 8'h00; s_addr_r = 8'h00;
    last_rd = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_chip_select", 32'(chip_select), 32'd1);
    chk("rst_read", 32'(read), 32'd1);
    chk("rst_write", 32'(write), 32'd1);
    chk("rst_a_d", 32'(a_d), 32'd0);
    chk("rst_bus_oe", 32'(bus_oe), 32'd0);
    chk("rst_bus_out", 32'(bus_out), 32'd0);
    chk("rst_acks", 32'({ack_w, ack_r}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fast_busy", 32'(s_busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single transactions from the vector table; inputs scrambled after grant.
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      rd_val = vec[v].rd_val;
      addr_w = vec[v].addr; wdata_w = vec[v].wdata; addr_r = vec[v].addr;
      push_exp(vec[v].is_w, vec[v].addr, vec[v].is_w ? vec[v].wdata : vec[v].rd_val);
      if (vec[v].is_w) req_w = 1'b1;
      else req_r = 1'b1;
      t0 = cyc;
      repeat (3) @(posedge clk);
      #1;
      addr_w = ~addr_w; wdata_w = ~wdata_w; addr_r = ~addr_r;
      wait_ev(vec[v].is_w ? 0 : 1, "vec_ack", t1);
      chk($sformatf("vec%0d_latency", v), 32'(t1 - t0), 32'(LAT));
      @(posedge clk); #1;
      req_w = 1'b0; req_r = 1'b0;
      if (!vec[v].is_w) last_rd = vec[v].rd_val;
      wait_ev(3, "vec_idle", t1);
      chk($sformatf("vec%0d_rdata_hold", v), 32'(rdata), 32'(last_rd));
    end

    // Simultaneous requests: W first, R starts T_GAP+1 after ack_w.
    @(posedge clk); #1;
    addr_w = 8'h10; wdata_w = 8'h11; addr_r = 8'h20; rd_val = 8'h5C;
    push_exp(1'b1, 8'h10, 8'h11);
    push_exp(1'b0, 8'h20, 8'h5C);
    req_w = 1'b1; req_r = 1'b1;
    t0 = cyc;
    wait_ev(0, "tie_ack_w", t1);
    chk("tie_w_latency", 32'(t1 - t0), 32'(LAT));
    @(posedge clk); #1;
    req_w = 1'b0;
    wait_ev(3, "tie_gap_idle", t2);
    wait_ev(2, "tie_r_start", t2);
    chk("tie_r_start_after_ack", 32'(t2 - t1), 32'(TG + 1));
    wait_ev(1, "tie_ack_r", t1);
    @(posedge clk); #1;
    req_r = 1'b0;
    wait_ev(3, "tie_idle", t1);

    // Both requests held: four grants alternating W,R,W,R.
    @(posedge clk); #1;
    addr_w = 8'h30; wdata_w = 8'h3A; addr_r = 8'h40; rd_val = 8'h6D;
    push_exp(1'b1, 8'h30, 8'h3A);
    push_exp(1'b0, 8'h40, 8'h6D);
    push_exp(1'b1, 8'h30, 8'h3A);
    push_exp(1'b0, 8'h40, 8'h6D);
    req_w = 1'b1; req_r = 1'b1;
    k = 0;
    for (int i = 0; i < 200 && k < 4; i++) begin
      @(negedge clk);
      if (ack_w || ack_r) k++;
    end
    @(posedge clk); #1;
    req_w = 1'b0; req_r = 1'b0;
    chk("rr_ack_count", 32'(k), 32'd4);
    wait_ev(3, "rr_idle", t1);
    chk("rr_scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Reset during the data strobe of a write aborts it without an ack.
    @(posedge clk); #1;
    addr_w = 8'h66; wdata_w = 8'h77; req_w = 1'b1;
    wait_ev(4, "abort_d_strobe", t1);
    @(posedge clk); #1;
    reset = 1'b0; req_w = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_chip_select", 32'(chip_select), 32'd1);
    chk("abort_write", 32'(write), 32'd1);
    chk("abort_bus_oe", 32'(bus_oe), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack_w || ack_r) k++;
    end
    chk("abort_no_ack", 32'(k), 32'd0);
    @(posedge clk); #1;
    push_exp(1'b1, 8'h66, 8'h77);
    req_w = 1'b1;
    t0 = cyc;
    wait_ev(2, "restart_busy", t2);
    chk("restart_a_setup", 32'(t2 - t0), 32'd1);
    wait_ev(0, "restart_ack", t1);
    chk("restart_latency", 32'(t1 - t0), 32'(LAT));
    @(posedge clk); #1;
    req_w = 1'b0;
    wait_ev(3, "restart_idle", t1);

    // Minimum timing instance: per-cycle waveform, ack 7 cycles after request.
    @(posedge clk); #1;
    s_addr_w = 8'h3C; s_wdata_w = 8'hC3; s_req_w = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk($sformatf("fast_w_cyc%0d", j), 32'({s_a_d, s_bus_oe, s_chip_select, s_write, s_read, s_ack_w, s_busy}), 32'(fast_w[j]));
      if (j >= 1 && j <= 6) chk($sformatf("fast_w_bus_out%0d", j), 32'(s_bus_out), (j < 4) ? 32'h3C : 32'hC3);
      if (j == 7) s_req_w = 1'b0;
    end
    @(posedge clk); #1;
    s_addr_r = 8'hA7; s_rd_val = 8'h9E; s_req_r = 1'b1;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk($sformatf("fast_r_cyc%0d", j), 32'({s_a_d, s_bus_oe, s_chip_select, s_write, s_read, s_ack_r, s_busy}), 32'(fast_r[j]));
      if (j >= 1 && j <= 3) chk($sformatf("fast_r_bus_out%0d", j), 32'(s_bus_out), 32'hA7);
      if (j == 7) begin
        chk("fast_r_rdata", 32'(s_rdata), 32'h9E);
        s_req_r = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
